// File: rtl/fifo_ctrl_pkg.sv
// Shared types and defaults for the FIFO controller and its wrapper.
package fifo_ctrl_pkg;

    localparam int unsigned DATA_W_DEF = 5;
    localparam int unsigned ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/fifo_ctrl.sv
// FIFO controller driving an external register-file memory: pointers, occupancy,
// status flags and sticky error flags.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DEPTH     = 2 ** ADDR_W,
    parameter int unsigned AF_THRESH = 12,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow_err,
    output logic              underflow_err,
    output logic              mem_write_rq,
    output logic              mem_read_rq,
    output logic [ADDR_W-1:0] mem_w_address,
    output logic [ADDR_W-1:0] mem_r_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int unsigned CntW = ADDR_W + 1;
    localparam logic [CntW-1:0] DepthC   = CntW'(DEPTH);
    localparam logic [CntW-1:0] DepthM1C = CntW'(DEPTH - 1);
    localparam logic [CntW-1:0] OneC     = CntW'(1);
    localparam logic [CntW-1:0] AfC      = CntW'(AF_THRESH);
    localparam logic [CntW-1:0] AeC      = CntW'(AE_THRESH);

    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic [DATA_W-1:0] data_out_q;
    logic              valid_out_q;
    logic              overflow_q, underflow_q;
    fifo_state_e       state_q, state_d;
    logic              push_ok, pop_ok;

    assign full  = (state_q == ST_FULL);
    assign empty = (state_q == ST_EMPTY);

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
    assign push_ok = push & (~full | pop) & ~rst;
    assign pop_ok  = pop & ~empty & ~rst;

    assign mem_write_rq   = push_ok;
    assign mem_read_rq    = pop_ok;
    assign mem_w_address  = wr_ptr_q;
    assign mem_r_address  = rd_ptr_q;
    assign mem_write_data = push_data;

    assign data_out      = data_out_q;
    assign valid_out     = valid_out_q;
    assign count         = count_q;
    assign almost_full   = (count_q >= AfC);
    assign almost_empty  = (count_q <= AeC);
    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + OneC;
            2'b01:   count_d = count_q - OneC;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (push_ok && !pop_ok) state_d = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (pop_ok && !push_ok && count_q == OneC) begin
                    state_d = ST_EMPTY;
                end else if (push_ok && !pop_ok && count_q == DepthM1C) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (pop_ok && !push_ok) state_d = ST_PARTIAL;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            state_q     <= ST_EMPTY;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            valid_out_q <= pop_ok;
            if (push_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (pop_ok) begin
                rd_ptr_q   <= rd_ptr_q + ADDR_W'(1);
                data_out_q <= mem_read_data;
            end
            if (push && full && !pop) overflow_q <= 1'b1;
            if (pop && empty) underflow_q <= 1'b1;
        end
    end

    // Keeps an otherwise unused parameter visible for wrapper consistency checks.
    logic unused_depth;
    assign unused_depth = ^DepthC;

endmodule
